kb_ascii_decoder: RTL
=====================

KB_ASCII_DECODER -- requirements
Module: kb_ascii_decoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port scan_data, input, 8, PS/2 set-2 byte from the receiver.
REQ-004 SHALL have port scan_valid, input, 1, one-cycle strobe qualifying scan_data.
REQ-005 SHALL have port ascii_out, output, 8, decoded character.
REQ-006 SHALL have port out_valid, output, 1, one-cycle strobe qualifying ascii_out.
REQ-007 SHALL have port kbsig, output, 16, key status: [0] shift held, [1] caps-lock state, [3] ctrl held, [5] right held, [6] left held, [7] down held, [8] up held, [9] backspace pulse; other bits 0.
REQ-008 SHALL use parameter PAUSE_SKIP, default 7, number of bytes discarded after an E1 prefix.

Function
REQ-009 SHALL decode with FSM states IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0), SKIP (after E1).
REQ-010 SHALL transition IDLE->BRK on F0, IDLE->EXT on E0, EXT->EXT_BRK on F0, IDLE->SKIP on E1; all other completed codes return to IDLE.
REQ-011 SHALL, in SKIP, count PAUSE_SKIP further strobes and then return to IDLE with no output.
REQ-012 SHALL drive out_valid high exactly one cycle after the scan_valid cycle carrying a mappable make code; ascii_out is held until the next strobe.
REQ-013 SHALL emit an output for every repeated make code (typematic), with no de-duplication.
REQ-014 SHALL emit nothing for break codes, modifier codes, and unmapped codes.
REQ-015 SHALL map letters to lowercase 0x61-0x7A, or uppercase when shift XOR caps.
REQ-016 SHALL map digits to 0x30-0x39 unshifted; shifted 8/9/0 to '*' 0x2A, '(' 0x28, ')' 0x29; '='(0x55) to 0x3D, shifted to '+' 0x2B; '-'(0x4E) to 0x2D; '/'(0x4A) to 0x2F.
REQ-017 SHALL map keypad 0x7C to 0x2A, 0x79 to 0x2B, 0x7B to 0x2D, E0 4A to 0x2F, Enter 0x5A and E0 5A to 0x0D, and Space 0x29 to 0x20.
REQ-018 SHALL NOT emit a character for backspace 0x66; instead kbsig[9] SHALL pulse for one cycle on each make, with out_valid low.
REQ-019 SHALL set kbsig[0] on make 0x12/0x59 and clear it on the break of either.
REQ-020 SHALL set kbsig[3] on make 0x14/E0 14 and clear it on either break.
REQ-021 SHALL toggle kbsig[1] on each caps make (0x58), including repeats after the first only once per press, i.e. toggle ignored until its break.
REQ-022 SHALL treat arrow codes E0 75/72/6B/74 as up/down/left/right, setting bits 8/7/6/5 on make and clearing on break, with no out_valid.
REQ-023 SHALL keep letter output with ctrl held unchanged (ctrl+D emits 0x64 with kbsig[3]=1 in the same cycle).
REQ-024 SHALL discard unknown E0 codes and return to IDLE.
REQ-025 SHALL ignore scan_valid while rst is high.

Reset
REQ-026 SHALL on rst set FSM to IDLE, the skip counter to 0, ascii_out to 0, out_valid to 0, kbsig to 0 (caps cleared), and the caps-press latch to 0.
REQ-027 SHALL discard any partial prefix sequence in progress when reset asserts mid-sequence; the next byte is decoded from IDLE.

Structure
REQ-028 SHALL keep scan-code constants (F0, E0, E1, modifier/arrow codes) and kbsig bit indices in a shared package kb_pkg, also used by the calculator consumer.
REQ-029 SHALL implement the code-to-ASCII table as a combinational sub-module scan_to_ascii (inputs: code, ext, upper; outputs: ascii, hit).

Verification
REQ-030 SHALL verify that strobing 0x23 produces out_valid the next cycle with ascii_out=0x64, then that F0 23 produces no output.
REQ-031 SHALL verify that 12, 46, F0 46, F0 12 yields one output of 0x28, with kbsig[0] high between 12 and F0 12.
REQ-032 SHALL verify that 14, 23 yields ascii_out=0x64 with kbsig[3]=1 in the out_valid cycle.
REQ-033 SHALL verify that 66 yields a one-cycle kbsig[9] pulse with out_valid=0; 66,66 yields two pulses.
REQ-034 SHALL verify that E0 6B sets kbsig[6]=1, E0 F0 6B clears it, and no out_valid occurs.
REQ-035 SHALL verify that 58, F0 58, 1C yields 0x41, and that rst asserted after E0, followed by 5A, yields 0x0D.

Source files
------------

// File: rtl/kb_pkg.sv
// Shared PS/2 set-2 scan-code constants and key-status bit positions, used by the
// decoder and by the calculator consumer.
package kb_pkg;

  localparam logic [7:0] ScBreak  = 8'hF0;
  localparam logic [7:0] ScExt    = 8'hE0;
  localparam logic [7:0] ScPause  = 8'hE1;
  localparam logic [7:0] ScLShift = 8'h12;
  localparam logic [7:0] ScRShift = 8'h59;
  localparam logic [7:0] ScCtrl   = 8'h14;
  localparam logic [7:0] ScCaps   = 8'h58;
  localparam logic [7:0] ScBksp   = 8'h66;
  localparam logic [7:0] ScUp     = 8'h75;
  localparam logic [7:0] ScDown   = 8'h72;
  localparam logic [7:0] ScLeft   = 8'h6B;
  localparam logic [7:0] ScRight  = 8'h74;

  localparam int unsigned KbShift = 0;
  localparam int unsigned KbCaps  = 1;
  localparam int unsigned KbCtrl  = 3;
  localparam int unsigned KbRight = 5;
  localparam int unsigned KbLeft  = 6;
  localparam int unsigned KbDown  = 7;
  localparam int unsigned KbUp    = 8;
  localparam int unsigned KbBksp  = 9;

  typedef logic [15:0] kbsig_t;

  function automatic logic is_alpha(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

endpackage

// File: rtl/scan_to_ascii.sv
// Combinational set-2 make-code to ASCII table; upper selects the shifted glyph.
module scan_to_ascii (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       upper,
  output logic [7:0] ascii,
  output logic       hit
);

  always_comb begin
    ascii = 8'h00;
    hit   = 1'b1;
    if (ext) begin
      case (code)
        8'h4A:   ascii = 8'h2F;
        8'h5A:   ascii = 8'h0D;
        default: hit = 1'b0;
      endcase
    end else begin
      // Letters: bit 5 clear selects uppercase
      case (code)
        8'h1C: ascii = {2'b01, ~upper, 5'd1};
        8'h32: ascii = {2'b01, ~upper, 5'd2};
        8'h21: ascii = {2'b01, ~upper, 5'd3};
        8'h23: ascii = {2'b01, ~upper, 5'd4};
        8'h24: ascii = {2'b01, ~upper, 5'd5};
        8'h2B: ascii = {2'b01, ~upper, 5'd6};
        8'h34: ascii = {2'b01, ~upper, 5'd7};
        8'h33: ascii = {2'b01, ~upper, 5'd8};
        8'h43: ascii = {2'b01, ~upper, 5'd9};
        8'h3B: ascii = {2'b01, ~upper, 5'd10};
        8'h42: ascii = {2'b01, ~upper, 5'd11};
        8'h4B: ascii = {2'b01, ~upper, 5'd12};
        8'h3A: ascii = {2'b01, ~upper, 5'd13};
        8'h31: ascii = {2'b01, ~upper, 5'd14};
        8'h44: ascii = {2'b01, ~upper, 5'd15};
        8'h4D: ascii = {2'b01, ~upper, 5'd16};
        8'h15: ascii = {2'b01, ~upper, 5'd17};
        8'h2D: ascii = {2'b01, ~upper, 5'd18};
        8'h1B: ascii = {2'b01, ~upper, 5'd19};
        8'h2C: ascii = {2'b01, ~upper, 5'd20};
        8'h3C: ascii = {2'b01, ~upper, 5'd21};
        8'h2A: ascii = {2'b01, ~upper, 5'd22};
        8'h1D: ascii = {2'b01, ~upper, 5'd23};
        8'h22: ascii = {2'b01, ~upper, 5'd24};
        8'h35: ascii = {2'b01, ~upper, 5'd25};
        8'h1A: ascii = {2'b01, ~upper, 5'd26};
        8'h16: ascii = upper ? 8'h21 : 8'h31;
        8'h1E: ascii = upper ? 8'h40 : 8'h32;
        8'h26: ascii = upper ? 8'h23 : 8'h33;
        8'h25: ascii = upper ? 8'h24 : 8'h34;
        8'h2E: ascii = upper ? 8'h25 : 8'h35;
        8'h36: ascii = upper ? 8'h5E : 8'h36;
        8'h3D: ascii = upper ? 8'h26 : 8'h37;
        8'h3E: ascii = upper ? 8'h2A : 8'h38;
        8'h46: ascii = upper ? 8'h28 : 8'h39;
        8'h45: ascii = upper ? 8'h29 : 8'h30;
        8'h55: ascii = upper ? 8'h2B : 8'h3D;
        8'h4E: ascii = 8'h2D;
        8'h4A: ascii = 8'h2F;
        8'h7C: ascii = 8'h2A;
        8'h79: ascii = 8'h2B;
        8'h7B: ascii = 8'h2D;
        8'h5A: ascii = 8'h0D;
        8'h29: ascii = 8'h20;
        default: hit = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/kb_ascii_decoder.sv
// PS/2 set-2 byte stream decoder: tracks prefixes and modifier state, emits one ASCII
// strobe per mappable make code and reports held keys on kbsig.
module kb_ascii_decoder
  import kb_pkg::*;
#(
  parameter int unsigned PAUSE_SKIP = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  scan_data,
  input  logic        scan_valid,
  output logic [7:0]  ascii_out,
  output logic        out_valid,
  output logic [15:0] kbsig
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StBrk    = 3'd1;
  localparam logic [2:0] StExt    = 3'd2;
  localparam logic [2:0] StExtBrk = 3'd3;
  localparam logic [2:0] StSkip   = 3'd4;

  localparam int unsigned CntW = (PAUSE_SKIP > 1) ? $clog2(PAUSE_SKIP) : 1;
  localparam logic [CntW-1:0] SkipLast = CntW'(PAUSE_SKIP - 1);

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] skip_q, skip_d;
  logic [7:0]      ascii_q, ascii_d;
  logic            valid_q, valid_d;
  kbsig_t          kbsig_q, kbsig_d;
  logic            caps_held_q, caps_held_d;

  logic [7:0] map_ascii, char_ascii;
  logic       map_hit;

  scan_to_ascii u_scan_to_ascii (
    .code  (scan_data),
    .ext   (state_q == StExt),
    .upper (kbsig_q[KbShift]),
    .ascii (map_ascii),
    .hit   (map_hit)
  );

  // Caps lock only inverts the case of letters, never the shifted symbol row
  assign char_ascii = (kbsig_q[KbCaps] && is_alpha(map_ascii)) ? (map_ascii ^ 8'h20) : map_ascii;

  always_comb begin
    state_d             = state_q;
    skip_d              = skip_q;
    ascii_d             = ascii_q;
    valid_d             = 1'b0;
    kbsig_d             = kbsig_q;
    kbsig_d[KbBksp]     = 1'b0;
    caps_held_d         = caps_held_q;
    if (scan_valid) begin
      case (state_q)
        StIdle: begin
          if (scan_data == ScBreak) begin
            state_d = StBrk;
          end else if (scan_data == ScExt) begin
            state_d = StExt;
          end else if (scan_data == ScPause) begin
            state_d = StSkip;
            skip_d  = '0;
          end else begin
            case (scan_data)
              ScLShift, ScRShift: kbsig_d[KbShift] = 1'b1;
              ScCtrl:             kbsig_d[KbCtrl] = 1'b1;
              ScCaps: begin
                if (!caps_held_q) begin
                  kbsig_d[KbCaps] = ~kbsig_q[KbCaps];
                  caps_held_d     = 1'b1;
                end
              end
              ScBksp:             kbsig_d[KbBksp] = 1'b1;
              default: begin
                if (map_hit) begin
                  valid_d = 1'b1;
                  ascii_d = char_ascii;
                end
              end
            endcase
          end
        end
        StBrk: begin
          state_d = StIdle;
          case (scan_data)
            ScLShift, ScRShift: kbsig_d[KbShift] = 1'b0;
            ScCtrl:             kbsig_d[KbCtrl] = 1'b0;
            ScCaps:             caps_held_d = 1'b0;
            default: ;
          endcase
        end
        StExt: begin
          if (scan_data == ScBreak) begin
            state_d = StExtBrk;
          end else begin
            state_d = StIdle;
            case (scan_data)
              ScCtrl:  kbsig_d[KbCtrl] = 1'b1;
              ScUp:    kbsig_d[KbUp] = 1'b1;
              ScDown:  kbsig_d[KbDown] = 1'b1;
              ScLeft:  kbsig_d[KbLeft] = 1'b1;
              ScRight: kbsig_d[KbRight] = 1'b1;
              default: begin
                if (map_hit) begin
                  valid_d = 1'b1;
                  ascii_d = char_ascii;
                end
              end
            endcase
          end
        end
        StExtBrk: begin
          state_d = StIdle;
          case (scan_data)
            ScCtrl:  kbsig_d[KbCtrl] = 1'b0;
            ScUp:    kbsig_d[KbUp] = 1'b0;
            ScDown:  kbsig_d[KbDown] = 1'b0;
            ScLeft:  kbsig_d[KbLeft] = 1'b0;
            ScRight: kbsig_d[KbRight] = 1'b0;
            default: ;
          endcase
        end
        StSkip: begin
          if (skip_q == SkipLast) begin
            state_d = StIdle;
            skip_d  = '0;
          end else begin
            skip_d = skip_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      skip_q      <= '0;
      ascii_q     <= 8'h00;
      valid_q     <= 1'b0;
      kbsig_q     <= '0;
      caps_held_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      ascii_q     <= ascii_d;
      valid_q     <= valid_d;
      kbsig_q     <= kbsig_d;
      caps_held_q <= caps_held_d;
    end
  end

  assign ascii_out = ascii_q;
  assign out_valid = valid_q;
  assign kbsig     = kbsig_q;

endmodule
